// File: rtl/conv_operand_feeder.sv
// Operand feeder / result collector for the CONV engine: host-loaded IFM and weight RAMs,
// 1-cycle read service, output counting/checksum. Define FEEDER_TIMEOUT_EN to add the RUN watchdog.
module conv_operand_feeder #(
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int IFM_SIZE     = 64,
    parameter int CI           = 3,
    parameter int CO           = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int OUT_COUNT    = 66*66*8,
    parameter int MAX_PASS     = CO,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic                    load_we,
    input  logic                    load_sel,
    input  logic [31:0]             load_addr,
    input  logic [((IFM_WIDTH > WEIGHT_WIDTH) ? IFM_WIDTH : WEIGHT_WIDTH)-1:0] load_data,
    input  logic                    start,
    output logic                    start_conv,
    input  logic                    ifm_read,
    output logic [IFM_WIDTH-1:0]    ifm,
    input  logic                    wgt_read,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    input  logic                    out_valid,
    input  logic [DATA_WIDTH-1:0]   data_output,
    input  logic                    end_conv,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             ofm_count,
    output logic [31:0]             checksum,
    output logic [15:0]             ifm_pass,
    output logic                    overrun,
    output logic                    timeout
);

    localparam int IFM_DEPTH = CI * IFM_SIZE * IFM_SIZE;
    localparam int WGT_DEPTH = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
    localparam int IFM_AW    = $clog2((IFM_DEPTH > 1) ? IFM_DEPTH : 2);
    localparam int WGT_AW    = $clog2((WGT_DEPTH > 1) ? WGT_DEPTH : 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;

    logic [IFM_WIDTH-1:0]    ifm_mem [IFM_DEPTH];
    logic [WEIGHT_WIDTH-1:0] wgt_mem [WGT_DEPTH];
    logic [IFM_AW-1:0]       ifm_ptr;
    logic [WGT_AW-1:0]       wgt_ptr;

    logic host_window;
    logic launch;
    logic ifm_wrap;
    logic wgt_wrap;
    logic ifm_over;
    logic out_full;
    logic out_over;
    logic wd_expire;

    assign host_window = (state == S_IDLE) || (state == S_DONE);
    assign launch      = host_window && start;
    assign ifm_wrap    = ifm_read && (ifm_ptr == IFM_AW'(IFM_DEPTH - 1));
    assign wgt_wrap    = wgt_read && (wgt_ptr == WGT_AW'(WGT_DEPTH - 1));
    // IFM may be replayed up to MAX_PASS times; weights are consumed exactly once per run.
    assign ifm_over    = ifm_wrap && (ifm_pass >= 16'(MAX_PASS));
    assign out_full    = (ofm_count == 32'(OUT_COUNT));
    assign out_over    = out_valid && out_full;

    // NOTE: RAMs have no reset so they map onto block memory; contents survive rst.
    always_ff @(posedge clk1) begin
        if (load_we && host_window) begin
            if (!load_sel && (load_addr < 32'(IFM_DEPTH)))
                ifm_mem[load_addr[IFM_AW-1:0]] <= load_data[IFM_WIDTH-1:0];
            if (load_sel && (load_addr < 32'(WGT_DEPTH)))
                wgt_mem[load_addr[WGT_AW-1:0]] <= load_data[WEIGHT_WIDTH-1:0];
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        timeout_flag;
    logic        activity;

    assign activity  = out_valid || ifm_read || wgt_read;
    assign wd_expire = (state == S_RUN) && !activity && (wd_cnt == 32'(TIMEOUT - 1));
    assign timeout   = timeout_flag;

    always_ff @(posedge clk1) begin
        if (rst) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (launch) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (state == S_RUN) begin
            if (activity)
                wd_cnt <= '0;
            else if (wd_expire)
                timeout_flag <= 1'b1;
            else
                wd_cnt <= wd_cnt + 32'd1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state      <= S_IDLE;
            start_conv <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ifm        <= '0;
            wgt        <= '0;
            ifm_ptr    <= '0;
            wgt_ptr    <= '0;
            ofm_count  <= '0;
            checksum   <= '0;
            ifm_pass   <= '0;
            overrun    <= 1'b0;
        end else begin
            // Read ports and the start strobe are single-cycle pulses by default.
            start_conv <= 1'b0;
            ifm        <= '0;
            wgt        <= '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_START;
                        start_conv <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        ifm_ptr    <= '0;
                        wgt_ptr    <= '0;
                        ofm_count  <= '0;
                        checksum   <= '0;
                        ifm_pass   <= '0;
                        overrun    <= 1'b0;
                    end
                end

                S_START: begin
                    state <= S_RUN;
                end

                S_RUN: begin
                    if (ifm_read) begin
                        ifm <= ifm_mem[ifm_ptr];
                        if (ifm_wrap) begin
                            ifm_ptr  <= '0;
                            ifm_pass <= ifm_pass + 16'd1;
                        end else begin
                            ifm_ptr <= ifm_ptr + IFM_AW'(1);
                        end
                    end

                    if (wgt_read) begin
                        wgt <= wgt_mem[wgt_ptr];
                        if (wgt_wrap)
                            wgt_ptr <= '0;
                        else
                            wgt_ptr <= wgt_ptr + WGT_AW'(1);
                    end

                    if (out_valid && !out_full) begin
                        ofm_count <= ofm_count + 32'd1;
                        checksum  <= checksum + 32'($signed(data_output));
                    end

                    if (ifm_over || wgt_wrap || out_over)
                        overrun <= 1'b1;

                    if (out_full || end_conv || wd_expire) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Directed bench for conv_operand_feeder: 4x4x1 IFM, CO=2 weights, OUT_COUNT=4, TIMEOUT=16.
module tb_conv_operand_feeder;

    localparam int IFM_SIZE    = 4;
    localparam int CI          = 1;
    localparam int CO          = 2;
    localparam int KERNEL_SIZE = 3;
    localparam int OUT_COUNT   = 4;
    localparam int MAX_PASS    = 1;
    localparam int TIMEOUT     = 16;

    logic        clk1 = 1'b0;
    logic        rst = 1'b0;
    logic        load_we = 1'b0;
    logic        load_sel = 1'b0;
    logic [31:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        start = 1'b0;
    logic        start_conv;
    logic        ifm_read = 1'b0;
    logic [7:0]  ifm;
    logic        wgt_read = 1'b0;
    logic [7:0]  wgt;
    logic        out_valid = 1'b0;
    logic [15:0] data_output = '0;
    logic        end_conv = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] ofm_count;
    logic [31:0] checksum;
    logic [15:0] ifm_pass;
    logic        overrun;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    conv_operand_feeder #(
        .IFM_WIDTH(8), .WEIGHT_WIDTH(8), .DATA_WIDTH(16),
        .IFM_SIZE(IFM_SIZE), .CI(CI), .CO(CO), .KERNEL_SIZE(KERNEL_SIZE),
        .OUT_COUNT(OUT_COUNT), .MAX_PASS(MAX_PASS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk1(clk1), .rst(rst),
        .load_we(load_we), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
        .start(start), .start_conv(start_conv),
        .ifm_read(ifm_read), .ifm(ifm), .wgt_read(wgt_read), .wgt(wgt),
        .out_valid(out_valid), .data_output(data_output), .end_conv(end_conv),
        .busy(busy), .done(done), .ofm_count(ofm_count), .checksum(checksum),
        .ifm_pass(ifm_pass), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic host_write(input logic sel, input int addr, input logic [7:0] val);
        load_we   = 1'b1;
        load_sel  = sel;
        load_addr = 32'(addr);
        load_data = val;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (start_conv !== 1'b0) begin bad++; $display("FAIL reset_start_conv: got %b want 0", start_conv); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        total++; if ({ifm, wgt} !== 16'h0) begin bad++; $display("FAIL reset_read_data: got %h want 0000", {ifm, wgt}); end
        total++; if (ofm_count !== 32'd0) begin bad++; $display("FAIL reset_ofm_count: got %0d want 0", ofm_count); end
        total++; if (checksum !== 32'd0) begin bad++; $display("FAIL reset_checksum: got %h want 0", checksum); end
        total++; if ({ifm_pass, overrun, timeout} !== 18'd0) begin bad++; $display("FAIL reset_pass_flags: got %h want 0", {ifm_pass, overrun, timeout}); end
    endtask

    task automatic test_load;
        for (int i = 0; i < 16; i++) host_write(1'b0, i, 8'(i + 1));
        for (int i = 0; i < 18; i++) host_write(1'b1, i, 8'(16 + i));
        host_write(1'b1, 18, 8'hEE);
    endtask

    task automatic test_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (start_conv !== 1'b1) begin bad++; $display("FAIL start_pulse_high: got %b want 1", start_conv); end
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL start_busy: got %b want 10", {busy, done}); end
        tick();
        total++; if (start_conv !== 1'b0) begin bad++; $display("FAIL start_pulse_low: got %b want 0", start_conv); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy: got %b want 1", busy); end
    endtask

    task automatic test_ifm_stream;
        logic [7:0] exp;
        // A host write during RUN must be ignored (checked after the mid-run reset).
        load_we   = 1'b1;
        load_sel  = 1'b0;
        load_addr = 32'd0;
        load_data = 8'h55;
        for (int i = 0; i < 17; i++) begin
            ifm_read = 1'b1;
            tick();
            load_we = 1'b0;
            exp = 8'((i % 16) + 1);
            total++; if (ifm !== exp) begin bad++; $display("FAIL ifm_stream[%0d]: got %0d want %0d", i, ifm, exp); end
        end
        ifm_read = 1'b0;
        total++; if (ifm_pass !== 16'd1) begin bad++; $display("FAIL ifm_pass_after_wrap: got %0d want 1", ifm_pass); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ifm_no_overrun: got %b want 0", overrun); end
        tick();
        total++; if (ifm !== 8'd0) begin bad++; $display("FAIL ifm_idle_zero: got %0d want 0", ifm); end
    endtask

    task automatic test_weights;
        logic [7:0] exp;
        for (int i = 0; i < 19; i++) begin
            wgt_read = 1'b1;
            ifm_read = (i == 0);
            tick();
            exp = 8'(16 + (i % 18));
            total++; if (wgt !== exp) begin bad++; $display("FAIL wgt_stream[%0d]: got %0d want %0d", i, wgt, exp); end
            if (i == 0) begin
                total++; if (ifm !== 8'd2) begin bad++; $display("FAIL dual_read_ifm: got %0d want 2", ifm); end
            end
        end
        wgt_read = 1'b0;
        ifm_read = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL wgt_overrun: got %b want 1", overrun); end
        total++; if (ifm_pass !== 16'd1) begin bad++; $display("FAIL wgt_ifm_pass: got %0d want 1", ifm_pass); end
        tick();
        total++; if (wgt !== 8'd0) begin bad++; $display("FAIL wgt_idle_zero: got %0d want 0", wgt); end
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
        total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL end_conv_done: got %b want 01", {busy, done}); end
        ifm_read = 1'b1;
        tick();
        ifm_read = 1'b0;
        total++; if (ifm !== 8'd0) begin bad++; $display("FAIL read_outside_run: got %0d want 0", ifm); end
        total++; if ({ifm_pass, overrun} !== {16'd1, 1'b1}) begin bad++; $display("FAIL done_hold: got %h want %h", {ifm_pass, overrun}, {16'd1, 1'b1}); end
    endtask

    task automatic test_out_capture;
        logic [15:0] vals [5];
        vals = '{16'd5, 16'hFFFD, 16'd7, 16'h7FFF, 16'h1234};
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({ifm_pass, overrun, done} !== 18'd0) begin bad++; $display("FAIL restart_clear: got %h want 0", {ifm_pass, overrun, done}); end
        tick();
        for (int i = 0; i < 5; i++) begin
            out_valid   = 1'b1;
            data_output = vals[i];
            tick();
            if (i == 3) begin
                total++; if (ofm_count !== 32'd4) begin bad++; $display("FAIL capture_count4: got %0d want 4", ofm_count); end
                total++; if (checksum !== 32'h0000_8008) begin bad++; $display("FAIL capture_sum4: got %h want 00008008", checksum); end
            end
        end
        out_valid = 1'b0;
        total++; if (ofm_count !== 32'd4) begin bad++; $display("FAIL extra_not_counted: got %0d want 4", ofm_count); end
        total++; if (checksum !== 32'h0000_8008) begin bad++; $display("FAIL extra_not_summed: got %h want 00008008", checksum); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL out_overrun: got %b want 1", overrun); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL count_done: got %b want 1", done); end
    endtask

    task automatic test_end_conv;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        out_valid   = 1'b1;
        data_output = 16'd1;
        tick();
        data_output = 16'd2;
        end_conv    = 1'b1;
        tick();
        out_valid = 1'b0;
        end_conv  = 1'b0;
        total++; if (ofm_count !== 32'd2) begin bad++; $display("FAIL end_conv_count: got %0d want 2", ofm_count); end
        total++; if (checksum !== 32'd3) begin bad++; $display("FAIL end_conv_sum: got %0d want 3", checksum); end
        total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL end_conv_state: got %b want 01", {busy, done}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({ofm_count, checksum} !== 64'd0) begin bad++; $display("FAIL restart_counters: got %h want 0", {ofm_count, checksum}); end
        total++; if ({start_conv, busy, done} !== 3'b110) begin bad++; $display("FAIL restart_state: got %b want 110", {start_conv, busy, done}); end
    endtask

    task automatic test_reset_midrun;
        tick();
        ifm_read    = 1'b1;
        out_valid   = 1'b1;
        data_output = 16'd9;
        tick();
        ifm_read  = 1'b0;
        out_valid = 1'b0;
        total++; if (ifm !== 8'd1) begin bad++; $display("FAIL midrun_first_read: got %0d want 1", ifm); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({start_conv, busy, done, ifm, wgt} !== 19'd0) begin bad++; $display("FAIL midrun_reset_outs: got %h want 0", {start_conv, busy, done, ifm, wgt}); end
        total++; if ({ofm_count, checksum} !== 64'd0) begin bad++; $display("FAIL midrun_reset_counters: got %h want 0", {ofm_count, checksum}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ifm_read = 1'b1;
        tick();
        ifm_read = 1'b0;
        total++; if (ifm !== 8'd1) begin bad++; $display("FAIL ram_intact: got %0d want 1", ifm); end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 15; i++) tick();
        total++; if ({timeout, busy} !== 2'b01) begin bad++; $display("FAIL wd_before_limit: got %b want 01", {timeout, busy}); end
        tick();
`ifdef FEEDER_TIMEOUT_EN
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL wd_timeout: got %b want 1", timeout); end
        total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL wd_done: got %b want 01", {busy, done}); end
`else
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL wd_tied_low: got %b want 0", timeout); end
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL wd_stays_run: got %b want 10", {busy, done}); end
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wd_end_conv_exit: got %b want 1", done); end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_start();
        test_ifm_stream();
        test_weights();
        test_out_capture();
        test_end_conv();
        test_reset_midrun();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_operand_feeder.md
# conv_operand_feeder

Synthesizable operand feeder and result collector that sits beside the `CONV` engine. It holds the input feature map (IFM) and weight sets in local RAM loaded by a host port, and issues `start_conv`. It serves the engine's `ifm_read` / `wgt_read` requests with one-cycle latency and counts, checksums and bounds the `out_valid` output stream. It generalises the streaming behaviour to arbitrary channel/kernel/size parameters and adds pass counting, an overrun error, a done handshake and an optional watchdog.

## Interface
Parameters:
- `IFM_WIDTH`, default 8: IFM element width.
- `WEIGHT_WIDTH`, default 8: weight element width.
- `DATA_WIDTH`, default 16: engine output width.
- `IFM_SIZE`, default 64: IFM height and width.
- `CI`, default 3: input channels.
- `CO`, default 8: output channels.
- `KERNEL_SIZE`, default 3: kernel height and width.
- `OUT_COUNT`, default 66*66*8: expected number of output words.
- `MAX_PASS`, default `CO`: maximum IFM passes before overrun.
- `TIMEOUT`, default 4096: watchdog limit in cycles. Used only with the watchdog macro.
- Derived: `IFM_DEPTH` = CI*IFM_SIZE*IFM_SIZE; `WGT_DEPTH` = CO*CI*KERNEL_SIZE*KERNEL_SIZE.

Ports:
- `clk1`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_we`  in  1  host write strobe.
- `load_sel`  in  1  0 = IFM RAM, 1 = weight RAM.
- `load_addr`  in  32  host write address.
- `load_data`  in  max(IFM_WIDTH, WEIGHT_WIDTH)  host write data; LSBs used.
- `start`  in  1  begin a run.
- `start_conv`  out  1  one-cycle start pulse to the engine.
- `ifm_read`  in  1  engine IFM request.
- `ifm`  out  IFM_WIDTH  IFM data.
- `wgt_read`  in  1  engine weight request.
- `wgt`  out  WEIGHT_WIDTH  weight data.
- `out_valid`  in  1  engine output strobe.
- `data_output`  in  DATA_WIDTH  engine output data.
- `end_conv`  in  1  engine end flag.
- `busy`  out  1  asserted in START and RUN.
- `done`  out  1  asserted in DONE.
- `ofm_count`  out  32  number of captured outputs.
- `checksum`  out  32  mod-2^32 sum of sign-extended outputs.
- `ifm_pass`  out  16  count of completed IFM wraps.
- `overrun`  out  1  sticky error flag.
- `timeout`  out  1  sticky watchdog flag; tied 0 without the macro.

## Operation
- States:
  - IDLE: `start` moves to START.
  - START: one cycle; `start_conv`=1; moves to RUN.
  - RUN: moves to DONE when `ofm_count` reaches OUT_COUNT, on `end_conv`, or on timeout.
  - DONE: `start` moves to START.
- Entering START clears both pointers, `ofm_count`, `checksum`, `ifm_pass`, `overrun` and `timeout`.
- Host writes:
  - Accepted only in IDLE and DONE.
  - Ignored in START and RUN, and when `load_addr` ≥ the selected depth.
  - RAM contents are not cleared by `rst`.
- IFM reads in RUN:
  - `ifm_read`=1 latches `ifm_mem[ifm_ptr]` and increments `ifm_ptr`.
  - At `IFM_DEPTH`-1 the pointer wraps to 0 and `ifm_pass` increments.
  - A wrap that makes `ifm_pass` exceed MAX_PASS sets `overrun`; reads continue.
- Weight reads in RUN:
  - Same as IFM, with wrap at `WGT_DEPTH`-1.
  - A wrap past the last weight sets `overrun`, since weights are read once per run.
- Read data outputs:
  - `ifm` / `wgt` show the latched word for exactly the cycle after the request.
  - They are 0 otherwise.
  - Requests outside RUN are ignored and return 0.
- Output capture:
  - In RUN, each `out_valid` increments `ofm_count` and adds sign-extended `data_output` to `checksum`.
  - `out_valid` after `ofm_count` = OUT_COUNT sets `overrun` and is not counted.
- Simultaneous events:
  - `end_conv` together with the final `out_valid`: the word is counted, then DONE.
  - `start` in START or RUN is ignored.
  - A simultaneous `ifm_read` and `wgt_read` are both served.

## Timing
- Read latency is 1 cycle: a request at edge N gives data valid from edge N+1 to edge N+2.
- `start_conv` rises one edge after `start` is sampled in IDLE or DONE.
- `done` and `busy` change on the edge the transition condition is sampled.
- Reset values:
  - State IDLE.
  - All outputs 0, including `start_conv`, `ifm`, `wgt`, `done`, `busy`, the counters and both flags.
- Reset mid-run aborts at the next edge; no partial-result hold.
- Back-to-back reads sustain 1 word per cycle per stream.
- Counters and flags hold their values in DONE until the next START.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - In RUN, a cycle counter clears on every `out_valid`, `ifm_read` or `wgt_read`.
  - Reaching TIMEOUT sets `timeout` and moves to DONE.
- Undefined: no watchdog logic; `timeout` is constant 0; RUN exits only on count or `end_conv`.

## Test plan
- Load 4x4x1 IFM with values 1..16, then `start` with one repeat pass -> `start_conv` pulses once, one edge after `start`. Sixteen consecutive reads return 1..16. The 17th read returns 1 and `ifm_pass`=1.
- With CO=2 and `WGT_DEPTH`=18, issue 19 weight reads -> the 19th read wraps to the first weight and `overrun`=1.
- With OUT_COUNT=4, drive `out_valid` with data 5, -3, 7, 0x7FFF -> `ofm_count`=4, `checksum`=0x0000_8008, then DONE. A fifth `out_valid` sets `overrun`.
- Assert `end_conv` with the 2nd `out_valid` -> `ofm_count`=2, `done`=1 on that edge. A later `start` clears all counters.
- Assert `rst` mid-RUN, then `start` again -> all outputs are 0 after the reset edge. RAM data is intact and the first read returns the first element.
- With `FEEDER_TIMEOUT_EN` and TIMEOUT=16, stall 16 cycles in RUN -> `timeout`=1 and DONE. Without the macro the bench stays in RUN.
